// File: rtl/mem_init_pkg.sv
// Shared constants for the memory initiator.
// Holds the FSM state encoding and response FIFO depth.
package mem_init_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_RUN   = 1'b0;
  localparam state_t ST_CLEAR = 1'b1;

  localparam int RSP_DEPTH = 2;

endpackage

// File: rtl/rsp_fifo.sv
// Small response FIFO for captured read data.
// Push and pop in the same cycle keep occupancy, even when full.
module rsp_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          valid,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;
  logic          do_push;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pop only real data; push when room exists or a pop frees a slot.
  always_comb begin
    do_pop  = pop & (count != '0);
    do_push = push & ((count != CW'(DEPTH)) | do_pop);
  end

  assign valid = (count != '0);
  assign dout  = mem[rd_ptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_initiator.sv
// Request/response front end for a one-cycle-latency SRAM.
// Credit-limited reads, free-flowing writes, and a zero-fill sweep.
module mem_initiator
  import mem_init_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [DW-1:0] req_be,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [DW-1:0] mem_be,
  output logic [DW-1:0] mem_din,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_dout
);

  localparam int CW = $clog2(RSP_DEPTH + 1);

  state_t        state;
  logic [AW-1:0] clr_cnt;
  logic          rd_pend;
  logic [CW-1:0] occ;
  logic [CW:0]   used;
  logic          run;
  logic          rsp_pop;
  logic          credit_ok;
  logic          accept;
  logic          clr_go;
  logic          clr_last;

  // Handshake and credit decode; a pop this cycle frees a credit.
  always_comb begin
    run       = (state == ST_RUN);
    rsp_pop   = rsp_valid & rsp_ready;
    used      = {1'b0, occ} + {{CW{1'b0}}, rd_pend}
              - {{CW{1'b0}}, rsp_pop};
    credit_ok = (used < (CW + 1)'(RSP_DEPTH));
    clr_go    = run & clr_start;
    req_ready = run & ~clr_start & (req_we | credit_ok);
    accept    = req_valid & req_ready;
    clr_last  = (clr_cnt == '1);
    clr_busy  = ~run;
  end

  // Memory port: sweep zeros while clearing, else pass the request.
  always_comb begin
    mem_cs   = accept;
    mem_we   = accept & req_we;
    mem_be   = req_be;
    mem_din  = req_wdata;
    mem_addr = req_addr;
    if (!run) begin
      mem_cs   = 1'b1;
      mem_we   = 1'b1;
      mem_be   = '1;
      mem_din  = '0;
      mem_addr = clr_cnt;
    end
  end

  // RUN/CLEAR sequencing; the counter wraps only on the last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_RUN;
      clr_cnt <= '0;
    end else begin
      unique case (1'b1)
        run: begin
          if (clr_go) state <= ST_CLEAR;
        end
        default: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_last) state <= ST_RUN;
        end
      endcase
    end
  end

  // One read in flight: data shows on mem_dout the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_pend <= 1'b0;
    else     rd_pend <= accept & ~req_we;
  end

  rsp_fifo #(
    .DW    (DW),
    .DEPTH (RSP_DEPTH),
    .CW    (CW)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_pend),
    .din   (mem_dout),
    .pop   (rsp_ready),
    .dout  (rsp_rdata),
    .valid (rsp_valid),
    .count (occ)
  );

endmodule

// File: doc/mem_initiator.md
MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 Parameters SHALL be: DW, default 32, data/bit-enable width; AW, default 6, address width; memory depth is 2**AW words.
REQ-002 clk  input  1  clock; all logic samples on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req_valid  input  1  a request is presented.
REQ-005 req_ready  output  1  a request is accepted when req_valid and req_ready are both high at a clock edge.
REQ-006 req_we  input  1  1=write, 0=read.
REQ-007 req_addr  input  AW  word address.
REQ-008 req_wdata  input  DW  write data.
REQ-009 req_be  input  DW  per-bit write enable.
REQ-010 rsp_valid  output  1  read data available.
REQ-011 rsp_ready  input  1  consumer accepts rsp_rdata.
REQ-012 rsp_rdata  output  DW  read data, in request order.
REQ-013 clr_start  input  1  single-cycle pulse; zero-fills the whole memory.
REQ-014 clr_busy  output  1  clear in progress.
REQ-015 mem_cs, mem_we  output  1 each  chip-select and write-enable, active high.
REQ-016 mem_be, mem_din  output  DW each; mem_addr  output  AW; mem_dout  input  DW  memory port.

Function
REQ-017 The memory side SHALL be combinational from the accepted request: mem_cs = req_valid & req_ready in run mode; mem_we/mem_addr/mem_din/mem_be follow req_*.
REQ-018 mem_dout SHALL be treated as valid during cycle N+1 for a read issued in cycle N and SHALL be captured at the end of cycle N+1 (one-cycle read latency).
REQ-019 Writes SHALL produce no response; a write may be accepted every cycle.
REQ-020 Captured read data SHALL enter a 2-entry response FIFO; rsp_valid = FIFO not empty; rsp_rdata = FIFO head.
REQ-021 A read SHALL be accepted only if (FIFO occupancy + reads in flight) < 2, so the FIFO never overflows; writes are not credit-limited.
REQ-022 Simultaneous FIFO push and pop SHALL keep occupancy unchanged, including at occupancy 2 (pop then push) and 0 never applies (push-only).
REQ-023 With rsp_ready held high, back-to-back reads SHALL sustain one read per cycle.
REQ-024 FSM states SHALL be RUN and CLEAR; RUN -> CLEAR on clr_start; CLEAR -> RUN after writing address 2**AW-1.
REQ-025 In CLEAR: req_ready=0; mem_cs=1, mem_we=1, mem_be all ones, mem_din=0, mem_addr = counter from 0 to 2**AW-1, one word per cycle; clr_busy=1.
REQ-026 clr_start while in CLEAR SHALL be ignored; clr_start in the same cycle as an accepted request SHALL take priority, and the request SHALL NOT be accepted that cycle.
REQ-027 A read in flight when CLEAR starts SHALL still land in the FIFO; responses SHALL drain during CLEAR.
REQ-028 The address counter SHALL wrap to 0 only on exit from CLEAR, never mid-clear.

Reset
REQ-029 On rst: FSM=RUN, FIFO empty, in-flight=0, counter=0; rsp_valid=0, clr_busy=0, mem_cs=0, mem_we=0, rsp_rdata=0.
REQ-030 rst asserted mid-CLEAR or with reads in flight SHALL abort the operation and discard pending data; memory contents are not restored.

Structure
REQ-031 The state enum (RUN, CLEAR) and the FIFO depth constant (2) SHALL live in a shared package, mem_init_pkg.
REQ-032 The response FIFO SHALL be a sub-module, rsp_fifo, parameterised by DW and depth.

Verification (bench uses dv_mem_model-equivalent SRAM, DW=32, AW=6)
REQ-033 Write 0xDEADBEEF to addr 5 with be=0xFFFFFFFF, then read addr 5 -> rsp_valid two cycles after read accept, rsp_rdata=0xDEADBEEF.
REQ-034 Write 0xFFFFFFFF then 0x00000000 with be=0x0000FFFF to addr 3; read -> 0xFFFF0000.
REQ-035 Hold rsp_ready=0, issue 4 reads -> exactly 2 accepted, req_ready low thereafter; release rsp_ready -> data returned in order, remaining reads accepted.
REQ-036 16 back-to-back reads with rsp_ready=1 -> 16 responses on 16 consecutive cycles, in order.
REQ-037 Fill memory, pulse clr_start -> clr_busy high for exactly 64 cycles, req_ready low throughout; all 64 reads then return 0.
REQ-038 Assert rst at cycle 20 of CLEAR and with 2 reads pending -> rsp_valid=0, clr_busy=0 immediately; req_ready=1 after reset release.
